bf16_to_fp8_quantizer: RTL and testbench
========================================

# bf16_to_fp8_quantizer

Output-side requantizer for the systolic array. It accepts the BF16 accumulator results drained from a PE column and converts each one to FP8 E4M3 (bias 7, flush-to-zero) for write-back. Conversion, saturation and tile-boundary tagging happen in a 2-stage valid/ready pipeline. It is the inverse of the FP8-to-BF16 decode at the PE inputs.

## Interface
- `TILE_LEN`, default 8: elements per drained tile. Must be ≥2. The tile counter is `$clog2(TILE_LEN)` bits wide.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `clear` input 1: synchronous tile abort.
- `in_valid` input 1: BF16 element present.
- `in_ready` output 1: element is accepted on `in_valid & in_ready`.
- `in_data` input 16: BF16 value {sign, exp[7:0], mant[6:0]}.
- `out_valid` output 1: FP8 element present.
- `out_ready` input 1: downstream accepts.
- `out_data` output 8: FP8 E4M3 value {sign, exp[3:0], mant[2:0]}.
- `out_last` output 1: marks the final element of a tile.
- `out_sat` output 1: this element was saturated (overflow or ±inf) or was a NaN.

## Operation
- **Stage 1 (classify/align):** register sign, NaN/inf/flush flags, `E = e - 120` (signed, 9 bits), kept mantissa `m[6:4]`, guard `m[3]`, and sticky `|m[2:0]`.
- **Stage 2 (round/pack):** produces `out_data`, `out_sat` and `out_last`.
- **Classification priority:**
  1. `e==0xFF`, `m!=0`: output `{s,7'h7F}` (NaN), `out_sat=1`.
  2. `e==0xFF`, `m==0`: output `{s,7'h7E}` (±448), `out_sat=1`.
  3. `e<=120`, which covers BF16 zero and denormals: output `{s,7'h00}`, `out_sat=0`. Flush uses the pre-round exponent; there is no round-up into the minimum normal.
  4. Otherwise round, then range-check.
- **Rounding:** RNE (see Configuration). Increment the 3-bit mantissa if `g & (sticky | lsb)`. A mantissa carry-out sets mantissa to 0 and does E+1.
- **Range check:** after rounding, `E>15`, or `E==15` with mantissa 7, outputs `{s,7'h7E}` with `out_sat=1`.
- **Tile counter:** increments on each accepted input. The element accepted when the count equals `TILE_LEN-1` is tagged last, and the counter wraps to 0. The tag travels with the data.
- **`clear`:** invalidates both stages and zeroes the counter. It has lower priority than `rst`. `in_valid` in the same cycle is ignored.
- **`rst`:** mid-operation it drops all in-flight data with no partial output.

## Timing
- **Stage advance:** `adv2 = !v2 | out_ready` and `adv1 = !v1 | adv2`. `in_ready = adv1 & !rst & !clear` (combinational).
- **Latency:** 2 cycles from acceptance to `out_valid` when there is no backpressure.
- **Throughput:** 1 element/cycle with `out_ready` held high.
- **Stability:** `out_data`, `out_last` and `out_sat` are registered. They hold stable while `out_valid & !out_ready`.
- **Backpressure:** no element is dropped or duplicated.
- **Full:** both stages full and `out_ready=0` gives `in_ready=0`.
- **Simultaneous events:** with both stages full, an output consume and an input accept in the same cycle both proceed.
- **Reset values:**
  - `out_valid=0`, `out_data=8'h00`, `out_last=0`, `out_sat=0`, counter 0, stage valids 0.
  - `in_ready=0` during the `rst` cycle and `1` the following cycle.

## Configuration
- `FP8_RNE_EN`
  - **Defined:** round-to-nearest-even as described above.
  - **Undefined:** truncation toward zero. No increment; guard and sticky are ignored, and the saturation checks remain.
- Pipeline depth and handshake behaviour are identical in both builds.

## Test plan
- **Basic conversion:** `0x3F80`, `0x4000`, `0xBF80` back-to-back with `out_ready=1` → `0x38`, `0x40`, `0xB8` on cycles 2, 3, 4 after the first accept, all with `out_sat=0`.
- **Rounding:**
  - `0x3F98` → `0x3A` with `FP8_RNE_EN`, `0x39` without.
  - `0x3F88` → `0x38` in both builds (tie to even).
- **Specials:**
  - `0x447A` (1000.0) → `0x7E`, `out_sat=1`.
  - `0xFF80` (-inf) → `0xFE`, `out_sat=1`.
  - `0x7FC0` → `0x7F`, `out_sat=1`.
  - `0x3C00` (2^-7) → `0x00`, `out_sat=0`.
- **Tile tagging, `TILE_LEN=8`:** stream 16 elements → `out_last=1` only on the 8th and 16th outputs.
- **Backpressure:** stream 6 elements with `out_ready` toggling 1,0,0,1,… → outputs in order with no loss. `in_ready` falls when both stages are full, and outputs hold stable while stalled.
- **Clear/reset mid-tile:**
  - Assert `clear` after 3 accepts with 2 elements in flight → no further `out_valid`; the next tile's 8th element carries `out_last`.
  - Repeat with `rst` → all outputs return to their reset values.

Source files
------------

// File: rtl/bf16_to_fp8_quantizer.sv
// BF16 -> FP8 E4M3 requantizer: 2-stage valid/ready pipeline with tile tagging.
// Define FP8_RNE_EN for round-to-nearest-even; otherwise mantissa truncates.
module bf16_to_fp8_quantizer #(
  parameter int TILE_LEN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        out_sat
);

  localparam int CW = $clog2(TILE_LEN);
  localparam logic [CW-1:0] LAST = CW'(TILE_LEN - 1);

  logic [CW-1:0] cnt;
  logic          v1, v2;
  logic          adv1, adv2, take;

  logic              s1, nan1, inf1, fl1, l1;
  logic signed [8:0] e1;
  logic [2:0]        m1;
`ifdef FP8_RNE_EN
  logic              g1, st1;
`endif

  logic       sgn;
  logic [7:0] ex_in;
  logic [6:0] mt_in;

  assign sgn   = in_data[15];
  assign ex_in = in_data[14:7];
  assign mt_in = in_data[6:0];

  assign adv2      = !v2 | out_ready;
  assign adv1      = !v1 | adv2;
  assign in_ready  = adv1 & !rst & !clear;
  assign take      = in_valid & in_ready;
  assign out_valid = v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      cnt <= '0;
    end else if (clear) begin
      v1  <= 1'b0;
      cnt <= '0;
    end else begin
      if (adv1)
        v1 <= take;
      if (take) begin
        s1   <= sgn;
        nan1 <= (&ex_in) & (|mt_in);
        inf1 <= (&ex_in) & ~(|mt_in);
        fl1  <= ex_in <= 8'd120;
        e1   <= $signed({1'b0, ex_in}) - 9'sd120;
        m1   <= mt_in[6:4];
`ifdef FP8_RNE_EN
        g1   <= mt_in[3];
        st1  <= |mt_in[2:0];
`endif
        l1   <= cnt == LAST;
        cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  logic              inc, cy, sat;
  logic [2:0]        mr;
  logic signed [8:0] er;
  logic [7:0]        pk;

  // Priority: NaN, inf, flush (pre-round exponent), then range check.
  always_comb begin
    inc = 1'b0;
`ifdef FP8_RNE_EN
    inc = g1 & (st1 | m1[0]);
`endif
    {cy, mr} = {1'b0, m1} + {3'b000, inc};
    er  = e1 + $signed({8'd0, cy});
    pk  = {s1, 7'h00};
    sat = 1'b0;
    if (nan1) begin
      pk  = {s1, 7'h7F};
      sat = 1'b1;
    end else if (inf1) begin
      pk  = {s1, 7'h7E};
      sat = 1'b1;
    end else if (fl1) begin
      pk  = {s1, 7'h00};
    end else if (er > 9'sd15 ||
                 (er == 9'sd15 && mr == 3'd7)) begin
      pk  = {s1, 7'h7E};
      sat = 1'b1;
    end else begin
      pk  = {s1, er[3:0], mr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2       <= 1'b0;
      out_data <= 8'h00;
      out_last <= 1'b0;
      out_sat  <= 1'b0;
    end else if (clear) begin
      v2 <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        out_data <= pk;
        out_sat  <= sat;
        out_last <= l1;
      end
    end
  end

endmodule

// File: tb/tb_bf16_to_fp8_quantizer.sv
// Directed table bench for bf16_to_fp8_quantizer (TILE_LEN=8).
module tb_bf16_to_fp8_quantizer;

`ifdef FP8_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_sat;

  logic or_man = 1'b1;
  logic bp_en = 1'b0;
  logic bp_r = 1'b1;
  assign out_ready = bp_en ? bp_r : or_man;

  bf16_to_fp8_quantizer #(.TILE_LEN(8)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       sat;
    logic       last;
    int         c;
  } obs_t;
  obs_t got[$];

  always @(negedge clk)
    if (out_valid && out_ready)
      got.push_back('{out_data, out_sat, out_last, cyc});

  logic       stab_en = 1'b0;
  logic       held = 1'b0;
  logic [9:0] hv = '0;
  logic       sawfull = 1'b0;
  always @(negedge clk) begin
    if (stab_en && held) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_data", int'({out_last, out_sat, out_data}), int'(hv));
    end
    held = out_valid && !out_ready;
    hv = {out_last, out_sat, out_data};
    if (bp_en && in_valid && !in_ready)
      sawfull = 1'b1;
  end

  int k_bp = 0;
  always @(posedge clk)
    if (bp_en) begin
      #1;
      bp_r = (k_bp % 4 == 0) || (k_bp % 4 == 3);
      k_bp++;
    end

  typedef struct {
    logic [15:0] i;
    logic [7:0]  d;
    logic        s;
  } vec_t;
  vec_t tv[20];

  task automatic send(input logic [15:0] d, output int acyc);
    logic r;
    int n;
    in_valid = 1'b1;
    in_data = d;
    acyc = -1;
    n = 0;
    r = 1'b0;
    while (!r && n < 100) begin
      @(negedge clk);
      r = in_ready;
      acyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    if (!r)
      chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int base, input int n);
    int k;
    k = 0;
    while (got.size() < base + n && k < 300) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("out_count", got.size() - base, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state",
        int'({out_valid, out_data, out_last, out_sat}), 0);
    chk("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic tail_tile(input string tag);
    int b, a;
    b = got.size();
    for (int i = 0; i < 8; i++)
      send(tv[i].i, a);
    wait_out(b, 8);
    if (got.size() >= b + 8) begin
      chk({tag, "_last6"}, int'(got[b+6].last), 0);
      chk({tag, "_last7"}, int'(got[b+7].last), 1);
      chk({tag, "_d7"}, int'(got[b+7].d), int'(tv[7].d));
    end
  endtask

  initial begin
    int a0, a, b;
    tv[0]  = '{16'h3F80, 8'h38, 1'b0};
    tv[1]  = '{16'h4000, 8'h40, 1'b0};
    tv[2]  = '{16'hBF80, 8'hB8, 1'b0};
    tv[3]  = '{16'h3F98, RNE ? 8'h3A : 8'h39, 1'b0};
    tv[4]  = '{16'h3F88, 8'h38, 1'b0};
    tv[5]  = '{16'h447A, 8'h7E, 1'b1};
    tv[6]  = '{16'hFF80, 8'hFE, 1'b1};
    tv[7]  = '{16'h7FC0, 8'h7F, 1'b1};
    tv[8]  = '{16'h3C00, 8'h00, 1'b0};
    tv[9]  = '{16'h3C80, 8'h08, 1'b0};
    tv[10] = '{16'h3C7F, 8'h00, 1'b0};
    tv[11] = '{16'h8000, 8'h80, 1'b0};
    tv[12] = '{16'h0001, 8'h00, 1'b0};
    tv[13] = '{16'hFFC1, 8'hFF, 1'b1};
    tv[14] = '{16'h7F80, 8'h7E, 1'b1};
    tv[15] = '{16'h4370, 8'h77, 1'b0};
    tv[16] = '{16'h4378, RNE ? 8'h78 : 8'h77, 1'b0};
    tv[17] = '{16'h43E0, 8'h7E, 1'b0};
    tv[18] = '{16'h43F0, 8'h7E, 1'b1};
    tv[19] = '{16'h43EC, 8'h7E, RNE};

    // table sweep, back to back with out_ready high
    do_reset();
    or_man = 1'b1;
    b = got.size();
    a0 = -1;
    for (int i = 0; i < 20; i++) begin
      send(tv[i].i, a);
      if (i == 0) a0 = a;
    end
    wait_out(b, 20);
    for (int i = 0; i < 20 && b + i < got.size(); i++) begin
      chk($sformatf("data[%0d]", i), int'(got[b+i].d), int'(tv[i].d));
      chk($sformatf("sat[%0d]", i), int'(got[b+i].sat), int'(tv[i].s));
      chk($sformatf("last[%0d]", i), int'(got[b+i].last),
          int'(i % 8 == 7));
      if (i < 3)
        chk($sformatf("lat[%0d]", i), got[b+i].c, a0 + 2 + i);
    end

    // 16-element tile tagging
    do_reset();
    b = got.size();
    for (int i = 0; i < 16; i++)
      send(tv[i].i, a);
    wait_out(b, 16);
    for (int i = 0; i < 16 && b + i < got.size(); i++)
      chk($sformatf("tile_last[%0d]", i), int'(got[b+i].last),
          int'(i == 7 || i == 15));

    // backpressure 1,0,0,1 pattern
    do_reset();
    b = got.size();
    k_bp = 0;
    bp_en = 1'b1;
    stab_en = 1'b1;
    sawfull = 1'b0;
    for (int i = 0; i < 6; i++)
      send(tv[i].i, a);
    wait_out(b, 6);
    stab_en = 1'b0;
    bp_en = 1'b0;
    for (int i = 0; i < 6 && b + i < got.size(); i++) begin
      chk($sformatf("bp_data[%0d]", i), int'(got[b+i].d), int'(tv[i].d));
      chk($sformatf("bp_sat[%0d]", i), int'(got[b+i].sat), int'(tv[i].s));
    end
    chk("bp_full_seen", int'(sawfull), 1);

    // clear mid-tile with two elements in flight
    do_reset();
    or_man = 1'b1;
    b = got.size();
    for (int i = 0; i < 3; i++)
      send(tv[i].i, a);
    clear = 1'b1;
    or_man = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h4000;
    @(negedge clk);
    chk("clr_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    or_man = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("clr_outs", got.size() - b, 1);
    if (got.size() > b)
      chk("clr_first", int'(got[b].d), 8'h38);
    tail_tile("clr");

    // reset mid-tile
    b = got.size();
    for (int i = 0; i < 3; i++)
      send(tv[i].i, a);
    rst = 1'b1;
    or_man = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    or_man = 1'b1;
    @(negedge clk);
    chk("mid_rst_state",
        int'({out_valid, out_data, out_last, out_sat}), 0);
    chk("mid_rst_in_ready1", int'(in_ready), 1);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_outs", got.size() - b, 1);
    tail_tile("rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
